// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV32 datapath (LW, SW, R-type, BEQ).
// Moore outputs per state; ir_write/pc_write also qualified by mem_ready/zero.
module multicycle_control (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  opcode,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        pc_write,
   output logic        ir_write,
   output logic        mem_read,
   output logic        mem_write,
   output logic        i_or_d,
   output logic        reg_write,
   output logic [1:0]  alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  alu_op,
   output logic [1:0]  result_src,
   output logic        illegal,
   output logic [3:0]  state,
   output logic [31:0] instret
);

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXEC_R    = 4'd6,
      S_ALU_WB    = 4'd7,
      S_BRANCH    = 4'd8,
      S_TRAP      = 4'd15
   } state_t;

   state_t cur, nxt;
   logic   retire;

   always_ff @(posedge clk) begin
      if (rst) begin
         cur     <= S_FETCH;
         instret <= '0;
      end else begin
         cur <= nxt;
         if (retire)
            instret <= instret + 32'd1;
      end
   end

   always_comb begin
      nxt        = cur;
      retire     = 1'b0;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      i_or_d     = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      result_src = 2'b00;
      illegal    = 1'b0;
      state      = cur;

      case (cur)
         S_FETCH: begin
            mem_read   = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               nxt      = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            case (opcode)
               OP_LW, OP_SW: nxt = S_MEM_ADDR;
               OP_R:         nxt = S_EXEC_R;
               OP_BEQ:       nxt = S_BRANCH;
               default:      nxt = S_TRAP;
            endcase
         end
         S_MEM_ADDR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            case (opcode)
               OP_LW:   nxt = S_MEM_READ;
               OP_SW:   nxt = S_MEM_WRITE;
               default: nxt = S_TRAP;
            endcase
         end
         S_MEM_READ: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
            if (mem_ready)
               nxt = S_MEM_WB;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            result_src = 2'b01;
            retire     = 1'b1;
            nxt        = S_FETCH;
         end
         S_MEM_WRITE: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
            if (mem_ready) begin
               retire = 1'b1;
               nxt    = S_FETCH;
            end
         end
         S_EXEC_R: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b10;
            nxt       = S_ALU_WB;
         end
         S_ALU_WB: begin
            reg_write = 1'b1;
            retire    = 1'b1;
            nxt       = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b01;
            pc_write  = zero;
            retire    = 1'b1;
            nxt       = S_FETCH;
         end
         S_TRAP: begin
            illegal = 1'b1;
            nxt     = S_TRAP;
         end
         default: nxt = S_TRAP;
      endcase

      // Reset overrides every write/request enable so an aborted instruction leaves no trace.
      if (rst) begin
         pc_write  = 1'b0;
         ir_write  = 1'b0;
         mem_read  = 1'b0;
         mem_write = 1'b0;
         reg_write = 1'b0;
         retire    = 1'b0;
      end
   end

endmodule
